ext_bus_sram_target: RTL

Single-port SRAM target that terminates the SoC external bus (the `bus_en` / `bus_we` / `bus_size` / `bus_addr` / `data_bus_drv` request and `bus_rdy` / `data_bus_recv` response). It sits directly downstream of the SoC top, provides the bus memory with programmable wait states, performs byte/half/word lane steering, and flags illegal accesses. Together with the SoC it forms a closed, simulation- and FPGA-ready system.

---
 rtl/ext_bus_sram_target_if.sv | 26 ++
 rtl/ext_bus_sram_target.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ext_bus_sram_target_if.sv
// SoC external-bus request/response bundle between the SoC master and the SRAM target.
// Request fields are held stable by the master until it samples bus_rdy=1.
interface ext_bus_sram_target_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_ADDR_WIDTH = 16
);
    logic                      bus_en;
    logic                      bus_we;
    logic [1:0]                bus_size;
    logic [EXT_ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0]     data_bus_drv;
    logic                      bus_rdy;
    logic [DATA_WIDTH-1:0]     data_bus_recv;
    logic                      bus_err;
    logic                      busy;

    modport master (
        output bus_en, bus_we, bus_size, bus_addr, data_bus_drv,
        input  bus_rdy, data_bus_recv, bus_err, busy
    );

    modport slave (
        input  bus_en, bus_we, bus_size, bus_addr, data_bus_drv,
        output bus_rdy, data_bus_recv, bus_err, busy
    );
endinterface

// File: rtl/ext_bus_sram_target.sv
// SRAM target for the SoC external bus: byte/half/word lane steering, legality check, programmable wait states.
// Latency: bus_rdy is high in the cycle after edge E+1+WAIT_STATES when bus_en is first sampled at edge E.
// Backpressure: master holds the request until bus_rdy; dropping bus_en during WAIT aborts with no access.
module ext_bus_sram_target #(
    parameter int DATA_WIDTH     = 32,
    parameter int EXT_ADDR_WIDTH = 16,
    parameter int MEM_WORDS      = 4096,
    parameter int WAIT_STATES    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    ext_bus_sram_target_if.slave   bus
);
    localparam int IDX_W  = EXT_ADDR_WIDTH - 2;
    localparam int MEM_AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    typedef struct packed {
        logic                      we;
        logic [1:0]                size;
        logic [EXT_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     dat;
    } req_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic                  rdy_q, rdy_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]      word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic [1:0]            lane;
    logic                  illegal;
    logic                  access;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdat;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] rd_steer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            S_IDLE: begin
                if (bus.bus_en) begin
                    req_d.we   = bus.bus_we;
                    req_d.size = bus.bus_size;
                    req_d.addr = bus.bus_addr;
                    req_d.dat  = bus.data_bus_drv;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.bus_en) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Index range is checked on the full word index so out-of-range addresses never alias into the array.
    assign word_idx = req_q.addr[EXT_ADDR_WIDTH-1:2];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign lane     = req_q.addr[1:0];
    assign illegal  = (req_q.size == 2'b11)
                   || (req_q.size == 2'b01 && lane[0])
                   || (req_q.size == 2'b10 && lane != 2'b00)
                   || !(32'(word_idx) < MEM_WORDS);
    assign access   = (state_q == S_WAIT) && bus.bus_en && (cnt_q == 4'd0);
    assign rd_word  = mem[mem_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        rdy_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        mem_be   = 4'b1111;
        mem_wdat = req_q.dat;
        rd_steer = rd_word;
        case (req_q.size)
            2'b00: begin
                mem_be   = 4'b0001 << lane;
                mem_wdat = {4{req_q.dat[7:0]}};
                rd_steer = rd_shift & 32'h0000_00FF;
            end
            2'b01: begin
                mem_be   = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdat = {2{req_q.dat[15:0]}};
                rd_steer = rd_shift & 32'h0000_FFFF;
            end
            default: ;
        endcase
        if (access) begin
            rdy_d = 1'b1;
            err_d = illegal;
            if (req_q.we) begin
                mem_we = !illegal;
            end else begin
                rdata_d = illegal ? '0 : rd_steer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
            end
        end
    end

    assign bus.bus_rdy       = rdy_q;
    assign bus.bus_err       = err_q;
    assign bus.data_bus_recv = rdata_q;
    assign bus.busy          = (state_q != S_IDLE);
endmodule
